// File: rtl/memoria_multiporta_if.sv
// Bus bundle for memoria_multiporta: one write port, NR read ports, status outputs.
// Requests carry no ready: a request is taken on any rising edge where busy=0, otherwise dropped.
interface memoria_multiporta_if #(
  parameter int N  = 1024,
  parameter int M  = 32,
  parameter int NR = 2
);
  localparam int IND_SIZE = $clog2(N);

  logic                   busy;
  logic                   dbg_state;
  logic                   wr_en;
  logic [IND_SIZE-1:0]    wr_ind;
  logic [M-1:0]           wr_dato;
  logic [NR-1:0]          rd_req;
  logic [NR*IND_SIZE-1:0] rd_ind;
  logic [NR*M-1:0]        rd_dato;
  logic [NR-1:0]          rd_valid;

  modport master (
    output wr_en, wr_ind, wr_dato, rd_req, rd_ind,
    input  busy, dbg_state, rd_dato, rd_valid
  );

  modport slave (
    input  wr_en, wr_ind, wr_dato, rd_req, rd_ind,
    output busy, dbg_state, rd_dato, rd_valid
  );
endinterface

// File: rtl/memoria_multiporta.sv
// N x M memory with one write port and NR pipelined read ports (latency LAT, valid flag).
// A clear sequencer zeroes the array after every reset; requests are ignored while it runs.
module memoria_multiporta #(
  parameter int N          = 1024,
  parameter int M          = 32,
  parameter int NR         = 2,
  parameter int LAT        = 2,
  parameter int WRITE_MODE = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  memoria_multiporta_if.slave   bus
);
  localparam int IND_SIZE = $clog2(N);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IND_SIZE-1:0] cnt_q, cnt_d;

  logic                mem_we;
  logic [IND_SIZE-1:0] mem_wa;
  logic [M-1:0]        mem_wd;
  logic                accept;

  logic [M-1:0]        mem_q [N];

  logic [IND_SIZE-1:0] rd_addr [NR];
  logic [M-1:0]        rd_raw  [NR];
  logic [NR-1:0]       rd_fire;

  logic [NR-1:0]       pval_q [LAT];
  logic [M-1:0]        pdat_q [LAT][NR];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    mem_wa  = bus.wr_ind;
    mem_wd  = bus.wr_dato;
    accept  = 1'b0;
    case (state_q)
      S_CLEAR: begin
        mem_we = 1'b1;
        mem_wa = cnt_q;
        mem_wd = '0;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == IND_SIZE'(N - 1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        mem_we = bus.wr_en;
        accept = 1'b1;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  assign bus.busy      = (state_q == S_CLEAR);
  assign bus.dbg_state = state_q;

  // The array itself has no reset: only the clear sequencer zeroes it.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  always_comb begin
    for (int p = 0; p < NR; p++) begin
      rd_addr[p] = bus.rd_ind[p*IND_SIZE +: IND_SIZE];
      rd_fire[p] = accept & bus.rd_req[p];
      if ((WRITE_MODE != 0) && accept && bus.wr_en && (bus.wr_ind == rd_addr[p]))
        rd_raw[p] = bus.wr_dato;
      else
        rd_raw[p] = mem_q[rd_addr[p]];
    end
  end

  // Data stages only load alongside a valid, so the output slice holds its last result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < LAT; s++) begin
        pval_q[s] <= '0;
        for (int p = 0; p < NR; p++) pdat_q[s][p] <= '0;
      end
    end else begin
      pval_q[0] <= rd_fire;
      for (int p = 0; p < NR; p++)
        if (rd_fire[p]) pdat_q[0][p] <= rd_raw[p];
      for (int s = 1; s < LAT; s++) begin
        pval_q[s] <= pval_q[s-1];
        for (int p = 0; p < NR; p++)
          if (pval_q[s-1][p]) pdat_q[s][p] <= pdat_q[s-1][p];
      end
    end
  end

  assign bus.rd_valid = pval_q[LAT-1];

  always_comb begin
    bus.rd_dato = '0;
    for (int p = 0; p < NR; p++) bus.rd_dato[p*M +: M] = pdat_q[LAT-1][p];
  end
endmodule
